// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: code image, pipeline control inputs, and IF/ID plus status outputs.
// The master side drives control and code; the slave side is the fetch unit.
interface fetch_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic [WIDTH*DEPTH-1:0] code;
  logic                   stall;
  logic                   flush;
  logic                   branch_taken;
  logic [WIDTH-1:0]       branch_target;
  logic [WIDTH-1:0]       pc;
  logic                   ifid_valid;
  logic [WIDTH-1:0]       ifid_instruction;
  logic [WIDTH-1:0]       ifid_pc_next;
  logic                   fault;
  logic [CNT_W-1:0]       fetch_count;

  modport master (
    output code, stall, flush, branch_taken, branch_target,
    input  pc, ifid_valid, ifid_instruction, ifid_pc_next, fault, fetch_count
  );

  modport slave (
    input  code, stall, flush, branch_taken, branch_target,
    output pc, ifid_valid, ifid_instruction, ifid_pc_next, fault, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, code-bus word select, IF/ID register, branch/stall/flush
// handling, bad-PC halt and a count of valid instructions delivered to decode.
module fetch_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  fetch_unit_if.slave bus
);
  localparam int unsigned STEP  = WIDTH / 8;
  localparam int unsigned AL    = $clog2(STEP);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  logic [0:0]       state, state_n;
  logic [WIDTH-1:0] pc_r, pc_n;
  logic [WIDTH-1:0] instr_r, instr_n;
  logic [WIDTH-1:0] pcn_r, pcn_n;
  logic             valid_r, valid_n;
  logic             fault_r, fault_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;

  logic [WIDTH-1:0] words [DEPTH];
  logic [WIDTH-1:0] word_idx;
  logic [IDX_W-1:0] sel;
  logic [WIDTH-1:0] fetch_word;
  logic [WIDTH-1:0] pc_step;
  logic             misaligned;
  logic             bad_pc;

  // Flat code bus viewed as an array of words
  for (genvar k = 0; k < DEPTH; k++) begin : g_words
    assign words[k] = bus.code[k*WIDTH +: WIDTH];
  end

  assign word_idx   = pc_r >> AL;
  assign sel        = word_idx[IDX_W-1:0];
  assign fetch_word = words[sel];
  assign pc_step    = pc_r + WIDTH'(STEP);
  assign misaligned = |pc_r[AL-1:0];
  assign bad_pc     = misaligned || (word_idx >= WIDTH'(DEPTH));

  // Next-state: redirect beats the bad-PC check, which beats stall
  always_comb begin
    state_n = state;
    pc_n    = pc_r;
    instr_n = instr_r;
    pcn_n   = pcn_r;
    valid_n = valid_r;
    fault_n = fault_r;
    cnt_n   = cnt_r;
    case (state)
      RUN: begin
        if (bus.branch_taken) begin
          pc_n    = bus.branch_target;
          valid_n = 1'b0;
          instr_n = '0;
          pcn_n   = '0;
        end else if (bad_pc) begin
          valid_n = 1'b0;
          instr_n = '0;
          pcn_n   = '0;
          fault_n = 1'b1;
          state_n = HALT;
        end else if (!bus.stall) begin
          pc_n = pc_step;
          if (bus.flush) begin
            valid_n = 1'b0;
            instr_n = '0;
            pcn_n   = '0;
          end else begin
            valid_n = 1'b1;
            instr_n = fetch_word;
            pcn_n   = pc_step;
            cnt_n   = cnt_r + CNT_W'(1);
          end
        end
      end
      HALT: begin
        valid_n = 1'b0;
      end
      default: begin
        state_n = HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      pc_r    <= WIDTH'(RESET_PC);
      instr_r <= '0;
      pcn_r   <= '0;
      valid_r <= 1'b0;
      fault_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state   <= state_n;
      pc_r    <= pc_n;
      instr_r <= instr_n;
      pcn_r   <= pcn_n;
      valid_r <= valid_n;
      fault_r <= fault_n;
      cnt_r   <= cnt_n;
    end
  end

  assign bus.pc               = pc_r;
  assign bus.ifid_valid       = valid_r;
  assign bus.ifid_instruction = instr_r;
  assign bus.ifid_pc_next     = pcn_r;
  assign bus.fault            = fault_r;
  assign bus.fetch_count      = cnt_r;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural fetch model queues the expected
// post-edge state; a monitor pops and compares after every rising edge.
module tb_fetch_unit;
  localparam int unsigned W    = 32;
  localparam int unsigned D    = 32;
  localparam int unsigned C    = 16;
  localparam int unsigned STEP = W / 8;
  localparam int unsigned W2   = 16;
  localparam int unsigned D2   = 8;

  logic clk = 1'b0;
  logic reset;
  logic reset2;
  always #5 clk = ~clk;

  fetch_unit_if #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) bus ();
  fetch_unit #(.WIDTH(W), .DEPTH(D), .RESET_PC(0), .CNT_W(C)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  fetch_unit_if #(.WIDTH(W2), .DEPTH(D2), .CNT_W(C)) bus2 ();
  fetch_unit #(.WIDTH(W2), .DEPTH(D2), .RESET_PC(0), .CNT_W(C)) dut2 (
    .clk(clk), .reset(reset2), .bus(bus2)
  );

  typedef struct {
    logic [W-1:0] pc;
    logic         valid;
    logic [W-1:0] instr;
    logic [W-1:0] pcn;
    logic         fault;
    logic [C-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state: program memory plus architectural view of the stage
  logic [W-1:0] mem [D];
  logic [W-1:0] m_pc, m_instr, m_pcn;
  logic         m_valid, m_halt;
  logic [C-1:0] m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_pc = '0; m_instr = '0; m_pcn = '0; m_valid = 1'b0; m_halt = 1'b0; m_cnt = '0;
  endfunction

  function automatic void model_bubble();
    m_valid = 1'b0; m_instr = '0; m_pcn = '0;
  endfunction

  function automatic void model_step(input logic br, input logic [W-1:0] tgt,
                                     input logic st, input logic fl);
    logic [W-1:0] nxt;
    if (m_halt) return;
    if (br) begin
      m_pc = tgt;
      model_bubble();
    end else if ((m_pc % STEP) != 0 || (m_pc / STEP) >= D) begin
      m_halt = 1'b1;
      model_bubble();
    end else if (!st) begin
      nxt = m_pc + W'(STEP);
      if (fl) model_bubble();
      else begin
        m_valid = 1'b1;
        m_instr = mem[m_pc / STEP];
        m_pcn   = nxt;
        m_cnt   = m_cnt + 1'b1;
      end
      m_pc = nxt;
    end
  endfunction

  // Entered at a falling edge; drives one cycle of stimulus, leaves at the next falling edge
  task automatic cycle(input logic br, input logic [W-1:0] tgt, input logic st, input logic fl);
    exp_t e;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.stall         = st;
    bus.flush         = fl;
    model_step(br, tgt, st, fl);
    e.pc = m_pc; e.valid = m_valid; e.instr = m_instr; e.pcn = m_pcn;
    e.fault = m_halt; e.cnt = m_cnt;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Asynchronous reset raised mid-cycle; outputs must clear before any clock edge
  task automatic reset_mid();
    #2 reset = 1'b1;
    #1;
    chk("rst_pc", bus.pc, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_valid", bus.ifid_valid, 0);
    chk("rst_count", bus.fetch_count, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Monitor: compare DUT against the oldest queued expectation after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc", bus.pc, e.pc);
        chk("ifid_valid", bus.ifid_valid, e.valid);
        chk("ifid_instruction", bus.ifid_instruction, e.instr);
        chk("ifid_pc_next", bus.ifid_pc_next, e.pcn);
        chk("fault", bus.fault, e.fault);
        chk("fetch_count", bus.fetch_count, e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int halt_cycles;
    logic br, st, fl;
    logic [W-1:0] tgt;
    int r;

    reset = 1'b1; reset2 = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
    bus2.stall = 1'b0; bus2.flush = 1'b0; bus2.branch_taken = 1'b0; bus2.branch_target = '0;
    for (int k = 0; k < D; k++) mem[k] = $urandom;
    mem[0] = 32'hAAAA_0001;
    mem[1] = 32'hBBBB_0002;
    for (int k = 0; k < D; k++) bus.code[k*W +: W] = mem[k];
    for (int k = 0; k < D2; k++) bus2.code[k*W2 +: W2] = 16'h1000 + 16'(k);

    @(negedge clk);
    chk("init_pc", bus.pc, 0);
    chk("init_valid", bus.ifid_valid, 0);
    chk("init_instr", bus.ifid_instruction, 0);
    chk("init_pc_next", bus.ifid_pc_next, 0);
    chk("init_fault", bus.fault, 0);
    chk("init_count", bus.fetch_count, 0);
    reset = 1'b0;
    model_reset();

    // Sequential fetch, stall hold (flush ignored while stalled), release
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 1);
    cycle(0, '0, 0, 0);
    // Branch overrides stall and flush; one bubble then word 4
    cycle(1, 32'h10, 1, 1);
    cycle(0, '0, 0, 0);
    // Flush alone at pc=4
    cycle(1, 32'h4, 0, 0);
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 0);
    // Out-of-range redirect halts; later inputs ignored
    cycle(1, 32'h80, 0, 0);
    cycle(0, '0, 0, 0);
    cycle(1, 32'h8, 1, 1);
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 0);
    reset_mid();
    // Misaligned redirect halts
    cycle(0, '0, 0, 0);
    cycle(1, 32'h6, 0, 0);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 1, 0);
    reset_mid();
    // Run off the end of the code image
    cycle(1, W'((D - 1) * STEP), 0, 0);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);
    reset_mid();

    // Randomized traffic with occasional bad targets; recover from halt by reset
    halt_cycles = 0;
    for (int n = 0; n < 800; n++) begin
      if (m_halt) begin
        halt_cycles++;
        if (halt_cycles > 3) begin
          reset_mid();
          halt_cycles = 0;
          continue;
        end
      end
      br = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 6) == 0);
      r  = int'($urandom_range(0, 19));
      if (r < 17)       tgt = W'($urandom_range(0, D - 1) * STEP);
      else if (r == 17) tgt = W'($urandom_range(0, D - 1) * STEP + $urandom_range(1, 3));
      else if (r == 18) tgt = W'((D + $urandom_range(0, 15)) * STEP);
      else              tgt = $urandom;
      cycle(br, tgt, st, fl);
    end
    chk("sb_drained", 64'(sb.size()), 0);

    // Narrow configuration: 2-byte step, 0x10 is past an 8-word image
    reset2 = 1'b0;
    @(negedge clk);
    chk("w16_pc1", bus2.pc, 16'h2);
    chk("w16_instr1", bus2.ifid_instruction, 16'h1000);
    chk("w16_pcn1", bus2.ifid_pc_next, 16'h2);
    @(negedge clk);
    chk("w16_pc2", bus2.pc, 16'h4);
    chk("w16_instr2", bus2.ifid_instruction, 16'h1001);
    chk("w16_count2", bus2.fetch_count, 2);
    bus2.branch_taken = 1'b1; bus2.branch_target = 16'h10;
    @(negedge clk);
    bus2.branch_taken = 1'b0;
    chk("w16_br_pc", bus2.pc, 16'h10);
    chk("w16_br_valid", bus2.ifid_valid, 0);
    chk("w16_br_fault", bus2.fault, 0);
    @(negedge clk);
    chk("w16_fault", bus2.fault, 1);
    chk("w16_fault_pc", bus2.pc, 16'h10);
    chk("w16_fault_count", bus2.fetch_count, 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
